// File: rtl/calculator_pkg.sv
// Shared calculator widths plus derived result-packer sizes.
// Exports DATA_W, MEM_WORD_SIZE, RP_LANES, RP_CNT_W.
package calculator_pkg;

   localparam int DATA_W        = 32;
   localparam int MEM_WORD_SIZE = 64;
   localparam int RP_LANES      = MEM_WORD_SIZE / DATA_W;
   localparam int RP_CNT_W      = $clog2(RP_LANES + 1);

endpackage

// File: rtl/result_packer_out_slot.sv
// One-deep valid/ready output register for packed words.
// Ports: clk_i, rst_i (sync active-low), load_i/word_i/mask_i in,
// ready_i from consumer, valid_o/word_o/mask_o out, slot_free_o.
module result_packer_out_slot #(
   parameter int WORD_W = 64,
   parameter int LANES  = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic [LANES-1:0]  mask_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [WORD_W-1:0] word_o,
   output logic [LANES-1:0]  mask_o,
   output logic              slot_free_o
);

   logic [WORD_W-1:0] out_q, out_d;
   logic [LANES-1:0]  mask_q, mask_d;
   logic              out_valid_q, out_valid_d;

   always_comb begin
      out_d       = out_q;
      mask_d      = mask_q;
      out_valid_d = out_valid_q;
      if (load_i) begin
         out_d       = word_i;
         mask_d      = mask_i;
         out_valid_d = 1'b1;
      end else if (ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         out_q       <= '0;
         mask_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         mask_q      <= mask_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign slot_free_o = !out_valid_q || ready_i;
   assign valid_o     = out_valid_q;
   assign word_o      = out_q;
   assign mask_o      = mask_q;

endmodule

// File: rtl/result_packer.sv
// Packs DATA_W results into MEM_WORD_SIZE words; emits full or flushed words.
// Ports: clk_i, rst_i (sync active-low), res_valid_i/res_ready_o/result_i,
// flush_i, word_valid_o/word_ready_i/word_o/lane_mask_o, busy_o.
// Macro RESULT_PACKER_MSB_FIRST_EN: fill lanes from the top lane downward.
module result_packer #(
   parameter int DATA_W        = calculator_pkg::DATA_W,
   parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     res_valid_i,
   output logic                     res_ready_o,
   input  logic [DATA_W-1:0]        result_i,
   input  logic                     flush_i,
   output logic                     word_valid_o,
   input  logic                     word_ready_i,
   output logic [MEM_WORD_SIZE-1:0] word_o,
   output logic [MEM_WORD_SIZE/DATA_W-1:0] lane_mask_o,
   output logic                     busy_o
);

   import calculator_pkg::*;

   localparam int LANES = MEM_WORD_SIZE / DATA_W;
   localparam int CNT_W = $clog2(LANES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

   logic [MEM_WORD_SIZE-1:0] asm_q, asm_d, asm_wr;
   logic [CNT_W-1:0]         cnt_q, cnt_d, eff_cnt, lane;
   logic                     flush_pend_q, flush_pend_d;
   logic                     slot_free, accept, complete;
   logic                     flush_new, load;
   logic [LANES-1:0]         mask_ld;

   assign res_ready_o = !flush_pend_q && !(cnt_q == LAST && !slot_free);
   assign accept      = res_valid_i && res_ready_o;
   assign complete    = accept && (cnt_q == LAST);
   assign eff_cnt     = cnt_q + CNT_W'(accept);

`ifdef RESULT_PACKER_MSB_FIRST_EN
   assign lane = LAST - cnt_q;
`else
   assign lane = cnt_q;
`endif

   // A flush alongside a completing accept is absorbed by the full word.
   assign flush_new = flush_i && !flush_pend_q
                   && (eff_cnt != '0) && !complete;

   assign load = complete
              || (flush_pend_q && slot_free)
              || (flush_new && slot_free);

   always_comb begin
      asm_wr  = asm_q;
      mask_ld = '0;
      for (int k = 0; k < LANES; k++) begin
         if (accept && lane == CNT_W'(k))
            asm_wr[k*DATA_W +: DATA_W] = result_i;
`ifdef RESULT_PACKER_MSB_FIRST_EN
         mask_ld[k] = CNT_W'(LANES - 1 - k) < eff_cnt;
`else
         mask_ld[k] = CNT_W'(k) < eff_cnt;
`endif
      end
   end

   always_comb begin
      asm_d        = asm_wr;
      cnt_d        = eff_cnt;
      flush_pend_d = flush_pend_q;
      if (flush_new && !slot_free)
         flush_pend_d = 1'b1;
      if (load) begin
         asm_d        = '0;
         cnt_d        = '0;
         flush_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         asm_q        <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         asm_q        <= asm_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   result_packer_out_slot #(
      .WORD_W (MEM_WORD_SIZE),
      .LANES  (LANES)
   ) u_out_slot (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (load),
      .word_i      (asm_wr),
      .mask_i      (mask_ld),
      .ready_i     (word_ready_i),
      .valid_o     (word_valid_o),
      .word_o      (word_o),
      .mask_o      (lane_mask_o),
      .slot_free_o (slot_free)
   );

   assign busy_o = (cnt_q != '0) || word_valid_o || flush_pend_q;

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: directed scenarios plus a
// randomized stream checked against an ordered list-of-words model.
module tb_result_packer;

   localparam int DW = 32;
   localparam int MW = 64;
   localparam int L  = MW / DW;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic          res_valid_i = 1'b0;
   logic          res_ready_o;
   logic [DW-1:0] result_i = '0;
   logic          flush_i = 1'b0;
   logic          word_valid_o;
   logic          word_ready_i = 1'b1;
   logic [MW-1:0] word_o;
   logic [L-1:0]  lane_mask_o;
   logic          busy_o;

   int n_cmp = 0;
   int n_err = 0;

   result_packer dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .res_valid_i  (res_valid_i),
      .res_ready_o  (res_ready_o),
      .result_i     (result_i),
      .flush_i      (flush_i),
      .word_valid_o (word_valid_o),
      .word_ready_i (word_ready_i),
      .word_o       (word_o),
      .lane_mask_o  (lane_mask_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   function automatic int lane_of(input int i);
`ifdef RESULT_PACKER_MSB_FIRST_EN
      return L - 1 - i;
`else
      return i;
`endif
   endfunction

   function automatic logic [MW-1:0] exp_word(input logic [DW-1:0] q[$]);
      logic [MW-1:0] w = '0;
      for (int i = 0; i < q.size(); i++)
         w[lane_of(i)*DW +: DW] = q[i];
      return w;
   endfunction

   function automatic logic [L-1:0] exp_mask(input int n);
      logic [L-1:0] m = '0;
      for (int i = 0; i < n; i++)
         m[lane_of(i)] = 1'b1;
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (word_valid_o !== 1'b0) begin
         n_err++; $display("FAIL reset_valid got=%b want=0", word_valid_o);
      end
      n_cmp++;
      if (word_o !== '0) begin
         n_err++; $display("FAIL reset_word got=%h want=0", word_o);
      end
      n_cmp++;
      if (lane_mask_o !== '0) begin
         n_err++; $display("FAIL reset_mask got=%b want=0", lane_mask_o);
      end
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_err++; $display("FAIL reset_busy got=%b want=0", busy_o);
      end
      n_cmp++;
      if (res_ready_o !== 1'b1) begin
         n_err++; $display("FAIL reset_ready got=%b want=1", res_ready_o);
      end
   endtask

   task automatic test_basic_pack();
      logic [DW-1:0] q[$];
      q = '{32'h1111_1111, 32'h2222_2222};
      tick();
      res_valid_i = 1'b1;
      result_i = q[0];
      tick();
      result_i = q[1];
      tick();
      res_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (word_valid_o !== 1'b1) begin
         n_err++; $display("FAIL pack_valid got=%b want=1", word_valid_o);
      end
      n_cmp++;
      if (word_o !== exp_word(q)) begin
         n_err++;
         $display("FAIL pack_word got=%h want=%h", word_o, exp_word(q));
      end
      n_cmp++;
      if (lane_mask_o !== exp_mask(2)) begin
         n_err++;
         $display("FAIL pack_mask got=%b want=%b", lane_mask_o, exp_mask(2));
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (word_valid_o !== 1'b0) begin
         n_err++; $display("FAIL pack_once got=%b want=0", word_valid_o);
      end
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_err++; $display("FAIL pack_idle got=%b want=0", busy_o);
      end
   endtask

   task automatic test_partial_flush();
      logic [DW-1:0] q[$];
      q = '{32'hAAAA_AAAA};
      tick();
      res_valid_i = 1'b1;
      result_i = q[0];
      tick();
      res_valid_i = 1'b0;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (word_valid_o !== 1'b1) begin
         n_err++; $display("FAIL pflush_valid got=%b want=1", word_valid_o);
      end
      n_cmp++;
      if (word_o !== exp_word(q)) begin
         n_err++;
         $display("FAIL pflush_word got=%h want=%h", word_o, exp_word(q));
      end
      n_cmp++;
      if (lane_mask_o !== exp_mask(1)) begin
         n_err++;
         $display("FAIL pflush_mask got=%b want=%b", lane_mask_o, exp_mask(1));
      end
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (word_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL empty_flush cyc=%0d got=%b want=0", i, word_valid_o);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] q0[$];
      logic [DW-1:0] q1[$];
      q0 = '{32'h10, 32'h20};
      q1 = '{32'h3, 32'h4};
      word_ready_i = 1'b0;
      res_valid_i = 1'b1;
      result_i = q0[0];
      tick();
      result_i = q0[1];
      tick();
      result_i = q1[0];
      @(negedge clk);
      n_cmp++;
      if (res_ready_o !== 1'b1) begin
         n_err++; $display("FAIL bp_ready_cnt0 got=%b want=1", res_ready_o);
      end
      tick();
      res_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (res_ready_o !== 1'b0) begin
         n_err++; $display("FAIL bp_ready_drop got=%b want=0", res_ready_o);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (word_o !== exp_word(q0) || word_valid_o !== 1'b1) begin
         n_err++;
         $display("FAIL bp_hold got=%h/%b want=%h/1",
                  word_o, word_valid_o, exp_word(q0));
      end
      word_ready_i = 1'b1;
      #1;
      n_cmp++;
      if (res_ready_o !== 1'b1) begin
         n_err++; $display("FAIL bp_ready_rise got=%b want=1", res_ready_o);
      end
      res_valid_i = 1'b1;
      result_i = q1[1];
      tick();
      res_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (word_valid_o !== 1'b1 || word_o !== exp_word(q1)) begin
         n_err++;
         $display("FAIL bp_next got=%h/%b want=%h/1",
                  word_o, word_valid_o, exp_word(q1));
      end
      n_cmp++;
      if (lane_mask_o !== exp_mask(2)) begin
         n_err++;
         $display("FAIL bp_mask got=%b want=%b", lane_mask_o, exp_mask(2));
      end
      tick();
   endtask

   task automatic test_flush_stall();
      logic [DW-1:0] q0[$];
      logic [DW-1:0] q1[$];
      q0 = '{32'h111, 32'h222};
      q1 = '{32'h333};
      word_ready_i = 1'b0;
      res_valid_i = 1'b1;
      result_i = q0[0];
      tick();
      result_i = q0[1];
      tick();
      result_i = q1[0];
      tick();
      res_valid_i = 1'b0;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (res_ready_o !== 1'b0 || busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL fs_pend ready=%b busy=%b want=0/1", res_ready_o, busy_o);
      end
      n_cmp++;
      if (word_o !== exp_word(q0)) begin
         n_err++;
         $display("FAIL fs_hold got=%h want=%h", word_o, exp_word(q0));
      end
      tick();
      tick();
      @(negedge clk);
      n_cmp++;
      if (res_ready_o !== 1'b0) begin
         n_err++; $display("FAIL fs_stall got=%b want=0", res_ready_o);
      end
      word_ready_i = 1'b1;
      tick();
      @(negedge clk);
      n_cmp++;
      if (word_valid_o !== 1'b1 || word_o !== exp_word(q1)) begin
         n_err++;
         $display("FAIL fs_word got=%h/%b want=%h/1",
                  word_o, word_valid_o, exp_word(q1));
      end
      n_cmp++;
      if (lane_mask_o !== exp_mask(1) || res_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL fs_mask got=%b rdy=%b want=%b rdy=1",
                  lane_mask_o, res_ready_o, exp_mask(1));
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (word_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL fs_drain valid=%b busy=%b want=0/0", word_valid_o, busy_o);
      end
   endtask

   task automatic test_reset_mid_word();
      logic [DW-1:0] q[$];
      q = '{32'h6, 32'h7};
      word_ready_i = 1'b1;
      tick();
      res_valid_i = 1'b1;
      result_i = 32'h5;
      tick();
      res_valid_i = 1'b0;
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (word_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL rmw_quiet cyc=%0d valid=%b busy=%b want=0/0",
                     i, word_valid_o, busy_o);
         end
         tick();
      end
      res_valid_i = 1'b1;
      result_i = q[0];
      tick();
      result_i = q[1];
      tick();
      res_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (word_valid_o !== 1'b1 || word_o !== exp_word(q)) begin
         n_err++;
         $display("FAIL rmw_word got=%h/%b want=%h/1",
                  word_o, word_valid_o, exp_word(q));
      end
      tick();
   endtask

   task automatic test_random();
      logic [DW-1:0] part[$];
      logic [MW-1:0] exp_w[$];
      logic [L-1:0]  exp_m[$];
      logic [MW-1:0] prev_w = '0;
      logic [L-1:0]  prev_m = '0;
      logic          prev_stall = 1'b0;
      int            n_words = 0;
      for (int c = 0; c < 460; c++) begin
         if (c < 400) begin
            res_valid_i  = ($urandom_range(0, 9) < 7);
            result_i     = $urandom();
            flush_i      = ($urandom_range(0, 9) == 0);
            word_ready_i = ($urandom_range(0, 9) < 6);
         end else begin
            res_valid_i  = 1'b0;
            flush_i      = (c == 405);
            word_ready_i = 1'b1;
         end
         @(negedge clk);
         if (prev_stall) begin
            n_cmp++;
            if (word_valid_o !== 1'b1 || word_o !== prev_w
                || lane_mask_o !== prev_m) begin
               n_err++;
               $display("FAIL rnd_hold cyc=%0d got=%h/%b want=%h/%b",
                        c, word_o, lane_mask_o, prev_w, prev_m);
            end
         end
         if (word_valid_o && word_ready_i) begin
            n_cmp++;
            if (exp_w.size() == 0) begin
               n_err++;
               $display("FAIL rnd_extra cyc=%0d got=%h want=none", c, word_o);
            end else begin
               if (word_o !== exp_w[0] || lane_mask_o !== exp_m[0]) begin
                  n_err++;
                  $display("FAIL rnd_word cyc=%0d got=%h/%b want=%h/%b",
                           c, word_o, lane_mask_o, exp_w[0], exp_m[0]);
               end
               void'(exp_w.pop_front());
               void'(exp_m.pop_front());
               n_words++;
            end
         end
         prev_stall = word_valid_o && !word_ready_i;
         prev_w = word_o;
         prev_m = lane_mask_o;
         if (res_valid_i && res_ready_o) begin
            part.push_back(result_i);
            if (part.size() == L) begin
               exp_w.push_back(exp_word(part));
               exp_m.push_back(exp_mask(L));
               part.delete();
            end
         end
         if (flush_i && part.size() > 0) begin
            exp_w.push_back(exp_word(part));
            exp_m.push_back(exp_mask(part.size()));
            part.delete();
         end
         tick();
      end
      flush_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (exp_w.size() != 0 || n_words < 20) begin
         n_err++;
         $display("FAIL rnd_drain left=%0d seen=%0d want=0/>=20",
                  exp_w.size(), n_words);
      end
   endtask

   initial begin
      test_reset();
      test_basic_pack();
      test_partial_flush();
      test_backpressure();
      test_flush_stall();
      test_reset_mid_word();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/result_packer.md
Name: result_packer

Overview:
- Parametrised successor to the two-slot result buffer.
- Auto-packs a stream of DATA_W ALU results into MEM_WORD_SIZE memory words, filling lanes in order without an external location select.
- Hands completed or flushed words to the memory writer over a valid/ready handshake, with a lane-valid mask for partial words.
- Sits between the ALU result path and the SRAM write controller.

Parameters:
- DATA_W, 32 (from calculator_pkg): width of one result.
- MEM_WORD_SIZE, 64 (from calculator_pkg): output word width; must be an integer multiple of DATA_W, ≥ 2×DATA_W.
- LANES, MEM_WORD_SIZE/DATA_W (derived localparam): results per word.
- CNT_W, $clog2(LANES+1) (derived localparam): lane counter width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset; synchronous, active-low.
- res_valid_i  in  1  result_i valid.
- res_ready_o  out  1  packer accepts result this cycle.
- result_i  in  DATA_W  ALU result.
- flush_i  in  1  single-cycle request to emit the partial word.
- word_valid_o  out  1  word_o/lane_mask_o valid.
- word_ready_i  in  1  memory writer consumes word this cycle.
- word_o  out  MEM_WORD_SIZE  packed word.
- lane_mask_o  out  LANES  bit k = lane k holds a result.
- busy_o  out  1  assembly or output slot non-empty, or flush pending.

Behaviour:
- State:
  - Assembly register asm_q (MEM_WORD_SIZE), lane count cnt_q (CNT_W), flush_pend_q.
  - One-deep output slot out_q / mask_q / out_valid_q.
- Reset (rst_i=0 at posedge): all registers zero; word_valid_o=0, word_o=0, lane_mask_o=0, busy_o=0. res_ready_o combinationally reflects the cleared state, so it is 1 during reset. Reset mid-word discards the partial data with no emission.
- Accept: res_valid_i && res_ready_o. result_i is written into lane cnt_q (bits [cnt_q*DATA_W +: DATA_W]) and cnt_q increments. Unwritten lanes keep the value 0.
- Slot free: slot_free = !out_valid_q || word_ready_i.
- Complete: an accept that fills lane LANES-1.
  - Next cycle: out_q holds the word, mask all-ones, word_valid_o=1.
  - asm_q and cnt_q clear the same cycle.
  - Latency from last-lane accept to word_valid_o is 1 cycle.
- res_ready_o = !flush_pend_q && !(cnt_q==LANES-1 && !slot_free). The path from word_ready_i to res_ready_o is combinational; this is intentional.
- Flush:
  - flush_i with effective count (cnt_q plus any same-cycle accept) equal to 0: ignored.
  - Otherwise, with slot_free: the partial word moves to the output next cycle, mask = low effective-count bits set.
  - Otherwise: flush_pend_q is set, input stalls, and the transfer happens on the first cycle slot_free=1, after which flush_pend_q clears.
  - A flush in the same cycle as a completing accept is absorbed; only one full word is emitted.
- Simultaneous accept + flush: the accepted lane is included in the flushed word.
- Output hold: while word_valid_o && !word_ready_i, word_o and lane_mask_o are stable.
- Back-to-back: with word_ready_i tied to 1, sustained 1 result/cycle throughput and no bubbles.
- Slot update:
  - out_valid_q clears on consume unless a new word loads the same cycle.
  - Consume and load in the same cycle is legal.
- busy_o = (cnt_q!=0) || out_valid_q || flush_pend_q.

Optional Feature:
- Macro: RESULT_PACKER_MSB_FIRST_EN.
- Defined: lanes fill from lane LANES-1 downward; the first result lands in [MEM_WORD_SIZE-1 -: DATA_W]. The partial-word mask sets the top effective-count bits.
- Undefined: LSB-first order as described above.
- Handshake, latency and flush semantics are identical in both builds.

Decomposition:
- calculator_pkg: DATA_W and MEM_WORD_SIZE (existing), plus new localparams RP_LANES and RP_CNT_W.
- Natural sub-module: result_packer_out_slot, the one-deep valid/ready output register (out_q, mask_q, out_valid_q, slot_free).
- Assembly, counter and flush logic stay in the top.

Test Plan (DATA_W=32, MEM_WORD_SIZE=64, word_ready_i=1 unless stated):
- Reset: hold rst_i=0 for 2 cycles, then release -> word_valid_o=0, word_o=0, lane_mask_o=0, busy_o=0, res_ready_o=1.
- Basic pack: accept 0x1111_1111 then 0x2222_2222 -> next cycle word_o=0x2222_2222_1111_1111, lane_mask_o=2'b11, valid for exactly 1 cycle.
- Partial flush: accept 0xAAAA_AAAA, then pulse flush_i -> word_o=0x0000_0000_AAAA_AAAA, mask=2'b01. A second flush with an empty assembly register emits nothing.
- Backpressure:
  - word_ready_i=0 with one full word pending.
  - Accept 0x3 -> res_ready_o drops (cnt_q=1); word_o stays stable.
  - Raise word_ready_i -> res_ready_o rises the same cycle; the next word is 0x4_0000_0003 after 0x4 is supplied.
- Flush under stall: slot full, cnt_q=1, flush_i -> flush_pend_q=1, res_ready_o=0. When the slot is freed, the partial word is emitted with mask 2'b01.
- Reset mid-word: accept 0x5, assert rst_i=0 -> no word is emitted. After release, accepting 0x6 and 0x7 yields 0x7_0000_0006.
- MSB_FIRST build: the basic-pack stimulus yields word_o=0x1111_1111_2222_2222; the partial flush yields mask=2'b10.
